imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 121 ++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Streams a little-endian byte image into instruction memory, pads the
// remainder with NOPs and holds the CPU in reset until the image is complete.
module imem_loader #(
  parameter int          WORD_DEPTH = 32,
  parameter logic [31:0] TEXT_BASE  = 32'h00010000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        last,
  output logic        byte_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst_n,
  output logic [31:0] eof_addr,
  output logic        done,
  output logic        overflow_err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PAD,
    DONE,
    ERR
  } state_t;

  localparam int          IW      = $clog2(WORD_DEPTH + 1);
  localparam logic [IW-1:0] DEPTH = IW'(WORD_DEPTH);
  localparam logic [31:0] PAD_END = TEXT_BASE + 32'(4 * (WORD_DEPTH - 1));
  localparam logic [31:0] NOP     = 32'h00000013;

  state_t        state, state_n;
  logic [IW-1:0] idx, idx_inc;
  logic [1:0]    bcnt;
  logic [31:0]   wbuf, pad_addr;
  logic [31:0]   word, cur_addr, next_addr;
  logic          acc, ovf, word_end;

  always_comb begin
    acc       = byte_valid && byte_ready;
    ovf       = acc && (bcnt == 2'd0) && (idx == DEPTH);
    word      = wbuf | (32'(byte_data) << {bcnt, 3'b000});
    word_end  = acc && !ovf && ((bcnt == 2'd3) || last);
    idx_inc   = idx + 1'b1;
    cur_addr  = TEXT_BASE + (32'(idx) << 2);
    next_addr = TEXT_BASE + (32'(idx_inc) << 2);
    state_n   = state;
    unique case (state)
      IDLE, DONE: if (start) state_n = LOAD;
      LOAD: begin
        if (ovf)
          state_n = ERR;
        else if (acc && last)
          state_n = (idx_inc < DEPTH) ? PAD : DONE;
      end
      PAD:  if (pad_addr == PAD_END) state_n = DONE;
      ERR:  state_n = ERR;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      bcnt         <= '0;
      wbuf         <= '0;
      pad_addr     <= '0;
      byte_ready   <= 1'b0;
      mem_wen      <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_rst_n    <= 1'b0;
      eof_addr     <= '0;
      done         <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      state      <= state_n;
      mem_wen    <= 1'b0;
      byte_ready <= (state_n == LOAD);
      // Release the CPU one cycle after the final write lands
      done       <= (state == DONE) && (state_n == DONE);
      cpu_rst_n  <= (state == DONE) && (state_n == DONE);
      if (state_n == ERR)
        overflow_err <= 1'b1;
      if ((state == IDLE || state == DONE) && start) begin
        idx  <= '0;
        bcnt <= '0;
        wbuf <= '0;
      end
      if (acc && !ovf) begin
        if (word_end) begin
          mem_wen   <= 1'b1;
          mem_addr  <= cur_addr;
          mem_wdata <= word;
          idx       <= idx_inc;
          bcnt      <= '0;
          wbuf      <= '0;
        end else begin
          wbuf <= word;
          bcnt <= bcnt + 2'd1;
        end
        if (last) begin
          eof_addr <= next_addr;
          pad_addr <= next_addr;
        end
      end
      if (state == PAD) begin
        mem_wen   <= 1'b1;
        mem_addr  <= pad_addr;
        mem_wdata <= NOP;
        pad_addr  <= pad_addr + 32'd4;
      end
    end
  end

endmodule
